// File: rtl/risk_cpu.sv
// Multi-cycle RV32I core (FETCH -> EXEC -> MEM) with Harvard instruction/data ports.
// Both memories answer combinationally in the cycle the address is driven, qualified by valid.
module risk_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid_i,
  input  logic        i_valid_d,
  input  logic [31:0] i_data_in_i,
  input  logic [31:0] i_data_in_d,
  output logic [31:0] o_addr_i,
  output logic [31:0] o_addr_d,
  output logic [3:0]  o_we_d,
  output logic        o_rd_d,
  output logic [31:0] o_data_out_d
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, ir;
  logic        pc_we, wb_en;
  logic [31:0] wb_data;
  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        f7_alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7_alt = ir[30];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u  = {ir[31:12], 12'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // regs[0] is cleared on reset and never written, so x0 reads as zero
  assign rs1_val  = regs[rs1];
  assign rs2_val  = regs[rs2];
  assign o_addr_i = pc;

  logic [31:0]        alu_b, alu_res;
  logic [4:0]         shamt;
  logic signed [31:0] sra_res;

  assign alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
  assign shamt   = alu_b[4:0];
  assign sra_res = $signed(rs1_val) >>> shamt;

  always_comb begin
    alu_res = '0;
    case (f3)
      3'b000:  alu_res = (opcode == OP_REG && f7_alt) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_res = rs1_val << shamt;
      3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_res = {31'b0, rs1_val < alu_b};
      3'b100:  alu_res = rs1_val ^ alu_b;
      3'b101:  alu_res = f7_alt ? sra_res : rs1_val >> shamt;
      3'b110:  alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  logic taken;
  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000:  taken = rs1_val == rs2_val;
      3'b001:  taken = rs1_val != rs2_val;
      3'b100:  taken = $signed(rs1_val) < $signed(rs2_val);
      3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  taken = rs1_val < rs2_val;
      3'b111:  taken = rs1_val >= rs2_val;
      default: taken = 1'b0;
    endcase
  end

  // Misaligned addresses are not trapped; the low bits only steer byte lanes
  logic [31:0] mem_addr, load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign ld_half  = mem_addr[1] ? i_data_in_d[31:16] : i_data_in_d[15:0];

  always_comb begin
    ld_byte = i_data_in_d[7:0];
    case (mem_addr[1:0])
      2'd0:    ld_byte = i_data_in_d[7:0];
      2'd1:    ld_byte = i_data_in_d[15:8];
      2'd2:    ld_byte = i_data_in_d[23:16];
      default: ld_byte = i_data_in_d[31:24];
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'b0, ld_byte};
      3'b101:  load_data = {16'b0, ld_half};
      default: load_data = i_data_in_d;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc + 32'd4;
    pc_we     = 1'b0;
    wb_en     = 1'b0;
    wb_data   = alu_res;
    case (state)
      FETCH: if (i_valid_i) state_nxt = EXEC;
      EXEC: begin
        state_nxt = FETCH;
        pc_we     = 1'b1;
        case (opcode)
          OP_LUI:   begin wb_en = 1'b1; wb_data = imm_u; end
          OP_AUIPC: begin wb_en = 1'b1; wb_data = pc + imm_u; end
          OP_JAL:   begin wb_en = 1'b1; wb_data = pc + 32'd4; pc_nxt = pc + imm_j; end
          OP_JALR:  begin wb_en = 1'b1; wb_data = pc + 32'd4;
                          pc_nxt = (rs1_val + imm_i) & ~32'd1; end
          OP_BRANCH: if (taken) pc_nxt = pc + imm_b;
          OP_IMM, OP_REG: wb_en = 1'b1;
          OP_LOAD, OP_STORE: begin state_nxt = MEM; pc_we = 1'b0; end
          default: ;
        endcase
      end
      MEM: if (i_valid_d) begin
        state_nxt = FETCH;
        pc_we     = 1'b1;
        wb_en     = (opcode == OP_LOAD);
        wb_data   = load_data;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= FETCH;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc <= RESET_PC;
      ir <= '0;
    end else begin
      if (state == FETCH && i_valid_i) ir <= i_data_in_i;
      if (pc_we) pc <= pc_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && rd != 5'd0) begin
      regs[rd] <= wb_data;
    end
  end

  // Data port is purely a function of state so an async reset drops it at once
  always_comb begin
    o_addr_d     = '0;
    o_rd_d       = 1'b0;
    o_we_d       = '0;
    o_data_out_d = '0;
    if (state == MEM) begin
      o_addr_d = mem_addr;
      if (opcode == OP_LOAD) begin
        o_rd_d = 1'b1;
      end else begin
        case (f3[1:0])
          2'b00: begin
            o_we_d       = 4'b0001 << mem_addr[1:0];
            o_data_out_d = {4{rs2_val[7:0]}};
          end
          2'b01: begin
            o_we_d       = 4'b0011 << {mem_addr[1], 1'b0};
            o_data_out_d = {2{rs2_val[15:0]}};
          end
          default: begin
            o_we_d       = 4'b1111;
            o_data_out_d = rs2_val;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_risk_cpu.sv
// Self-checking bench for risk_cpu: behavioural I/D memories, a store scoreboard,
// a table of ALU vectors and hand-written branch/stall/reset sequences.
module tb_risk_cpu;

  logic        i_clk, i_rst, i_valid_i, i_valid_d;
  logic [31:0] i_data_in_i, i_data_in_d;
  logic [31:0] o_addr_i, o_addr_d, o_data_out_d;
  logic [3:0]  o_we_d;
  logic        o_rd_d;

  risk_cpu dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid_i(i_valid_i), .i_valid_d(i_valid_d),
    .i_data_in_i(i_data_in_i), .i_data_in_d(i_data_in_d),
    .o_addr_i(o_addr_i), .o_addr_d(o_addr_d), .o_we_d(o_we_d),
    .o_rd_d(o_rd_d), .o_data_out_d(o_data_out_d)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];

  assign i_data_in_i = imem[o_addr_i[9:2]];
  assign i_data_in_d = dmem[o_addr_d[9:2]];

  always @(posedge i_clk) begin
    if (!i_rst && i_valid_d) begin
      for (int n = 0; n < 4; n++)
        if (o_we_d[n]) dmem[o_addr_d[9:2]][8*n +: 8] = o_data_out_d[8*n +: 8];
    end
  end

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } store_t;
  store_t expq[$];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[16];

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] stype(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] btype(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] utype(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] jtype(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LDO = 7'b0000011;
  localparam logic [31:0] LOOP = 32'h0000_006F;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Every completed store is compared against the next expected record
  always @(negedge i_clk) begin
    if (!i_rst && i_valid_d && o_we_d != 4'b0000) begin
      checkCount++;
      if (expq.size() == 0) begin
        $display("[TB] FAIL unexpected store: addr %h we %b data %h", o_addr_d, o_we_d, o_data_out_d);
      end else begin
        store_t e;
        e = expq.pop_front();
        if (o_addr_d === e.addr && o_we_d === e.we && o_data_out_d === e.data)
          passCount++;
        else
          $display("[TB] FAIL store: got addr %h we %b data %h, expected addr %h we %b data %h",
                   o_addr_d, o_we_d, o_data_out_d, e.addr, e.we, e.data);
      end
    end
  end

  task automatic expectStore(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
    store_t e;
    e.addr = addr; e.we = we; e.data = data;
    expq.push_back(e);
  endtask

  task automatic startReset();
    i_rst = 1'b1;
    @(posedge i_clk);
    for (int i = 0; i < 256; i++) begin
      imem[i] = LOOP;
      dmem[i] = '0;
    end
    expq.delete();
  endtask

  task automatic releaseReset();
    repeat (4) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int cyc = 0;
    while (expq.size() != 0 && cyc < 300) begin
      @(posedge i_clk);
      cyc++;
    end
    #1;
    if (expq.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL %s: %0d stores still pending, expected 0", name, expq.size());
      expq.delete();
    end
  endtask

  task automatic checkAfter(input int n, input logic [31:0] exp, input string name);
    repeat (n) @(posedge i_clk);
    #1 checkOutput(name, o_addr_i, exp);
  endtask

  // x1 and x2 are loaded from memory, the op writes x3, x3 is stored to 0x8
  task automatic applyStimulus(input vec_t v);
    startReset();
    dmem[0] = v.a;
    dmem[1] = v.b;
    imem[0] = itype(12'h000, 5'd0, 3'b010, 5'd1, LDO);
    imem[1] = itype(12'h004, 5'd0, 3'b010, 5'd2, LDO);
    imem[2] = v.instr;
    imem[3] = stype(12'h008, 5'd3, 5'd0, 3'b010);
    expectStore(32'h8, 4'b1111, v.exp);
    releaseReset();
    waitDrain("alu vector");
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    i_rst = 1'b1; i_valid_i = 1'b1; i_valid_d = 1'b1;

    vecs[0]  = '{rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5,         32'd7,         32'd12};
    vecs[1]  = '{rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5,         32'd7,         32'hFFFF_FFFE};
    vecs[2]  = '{rtype(7'h00, 5'd2, 5'd1, 3'b001, 5'd3), 32'd1,         32'd33,        32'd2};
    vecs[3]  = '{rtype(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'hFFFF_FFFF, 32'd1,         32'd1};
    vecs[4]  = '{rtype(7'h00, 5'd2, 5'd1, 3'b011, 5'd3), 32'hFFFF_FFFF, 32'd1,         32'd0};
    vecs[5]  = '{rtype(7'h00, 5'd2, 5'd1, 3'b100, 5'd3), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vecs[6]  = '{rtype(7'h00, 5'd2, 5'd1, 3'b101, 5'd3), 32'h8000_0000, 32'd4,         32'h0800_0000};
    vecs[7]  = '{rtype(7'h20, 5'd2, 5'd1, 3'b101, 5'd3), 32'h8000_0000, 32'd4,         32'hF800_0000};
    vecs[8]  = '{rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd3), 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F};
    vecs[9]  = '{rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'd3), 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000};
    vecs[10] = '{itype(12'hFFF, 5'd1, 3'b000, 5'd3, OPI), 32'd0,         32'd0,         32'hFFFF_FFFF};
    vecs[11] = '{rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'hFFFF_FFFF, 32'd1,         32'd0};
    vecs[12] = '{itype(12'hFFF, 5'd1, 3'b010, 5'd3, OPI), 32'hFFFF_FFFE, 32'd0,         32'd1};
    vecs[13] = '{itype(12'hFFF, 5'd1, 3'b011, 5'd3, OPI), 32'd5,         32'd0,         32'd1};
    vecs[14] = '{itype(12'h41F, 5'd1, 3'b101, 5'd3, OPI), 32'h8000_0000, 32'd0,         32'hFFFF_FFFF};
    vecs[15] = '{itype(12'hFFF, 5'd1, 3'b100, 5'd3, OPI), 32'h1234_5678, 32'd0,         32'hEDCB_A987};

    // Reset values and first fetch timing
    startReset();
    imem[0] = itype(12'h001, 5'd0, 3'b000, 5'd1, OPI);
    repeat (4) @(posedge i_clk);
    #1;
    checkOutput("reset addr_i", o_addr_i, 32'h0);
    checkOutput("reset rd_d", {31'b0, o_rd_d}, 32'h0);
    checkOutput("reset we_d", {28'b0, o_we_d}, 32'h0);
    i_rst = 1'b0;
    checkAfter(1, 32'h0, "first fetch addr_i");
    checkAfter(1, 32'h4, "addr_i after first instr");

    for (int k = 0; k < 16; k++) applyStimulus(vecs[k]);

    // Stores, byte/half lanes, sign/zero-extending loads, x0 writes discarded
    startReset();
    imem[0]  = itype(12'h005, 5'd0, 3'b000, 5'd1, OPI);
    imem[1]  = itype(12'hFF9, 5'd1, 3'b000, 5'd2, OPI);
    imem[2]  = stype(12'h100, 5'd2, 5'd0, 3'b010);
    imem[3]  = stype(12'h103, 5'd1, 5'd0, 3'b000);
    imem[4]  = utype(20'h80000, 5'd4, 7'b0110111);
    imem[5]  = stype(12'h100, 5'd4, 5'd0, 3'b010);
    imem[6]  = itype(12'h103, 5'd0, 3'b000, 5'd3, LDO);
    imem[7]  = stype(12'h104, 5'd3, 5'd0, 3'b010);
    imem[8]  = itype(12'h103, 5'd0, 3'b100, 5'd3, LDO);
    imem[9]  = stype(12'h108, 5'd3, 5'd0, 3'b010);
    imem[10] = itype(12'h102, 5'd0, 3'b001, 5'd3, LDO);
    imem[11] = stype(12'h10C, 5'd3, 5'd0, 3'b010);
    imem[12] = stype(12'h10E, 5'd1, 5'd0, 3'b001);
    imem[13] = itype(12'h005, 5'd0, 3'b000, 5'd0, OPI);
    imem[14] = stype(12'h110, 5'd0, 5'd0, 3'b010);
    expectStore(32'h100, 4'b1111, 32'hFFFF_FFFE);
    expectStore(32'h103, 4'b1000, 32'h0505_0505);
    expectStore(32'h100, 4'b1111, 32'h8000_0000);
    expectStore(32'h104, 4'b1111, 32'hFFFF_FF80);
    expectStore(32'h108, 4'b1111, 32'h0000_0080);
    expectStore(32'h10C, 4'b1111, 32'hFFFF_8000);
    expectStore(32'h10E, 4'b1100, 32'h0005_0005);
    expectStore(32'h110, 4'b1111, 32'h0000_0000);
    releaseReset();
    waitDrain("load/store sequence");

    // Control flow: jumps, all branch flavours, JALR bit-0 clear, AUIPC
    startReset();
    imem[0]  = jtype(21'h20, 5'd0);
    imem[8]  = btype(13'd16, 5'd0, 5'd0, 3'b000);
    imem[12] = btype(13'd16, 5'd0, 5'd0, 3'b001);
    imem[13] = utype(20'h00010, 5'd5, 7'b0110111);
    imem[14] = itype(12'h041, 5'd5, 3'b000, 5'd5, OPI);
    imem[15] = itype(12'h000, 5'd5, 3'b000, 5'd6, 7'b1100111);
    imem[16] = stype(12'h120, 5'd6, 5'd0, 3'b010);
    imem[17] = itype(12'hFFF, 5'd0, 3'b000, 5'd7, OPI);
    imem[18] = btype(13'd8, 5'd0, 5'd7, 3'b100);
    imem[20] = btype(13'd8, 5'd0, 5'd7, 3'b110);
    imem[21] = btype(13'd8, 5'd7, 5'd0, 3'b101);
    imem[23] = btype(13'd8, 5'd7, 5'd0, 3'b111);
    imem[24] = jtype(21'd8, 5'd8);
    imem[26] = stype(12'h124, 5'd8, 5'd0, 3'b010);
    imem[27] = utype(20'h00001, 5'd9, 7'b0010111);
    imem[28] = stype(12'h128, 5'd9, 5'd0, 3'b010);
    expectStore(32'h120, 4'b1111, 32'h0000_0040);
    expectStore(32'h124, 4'b1111, 32'h0001_0064);
    expectStore(32'h128, 4'b1111, 32'h0001_106C);
    releaseReset();
    checkAfter(2, 32'h20,    "jal target");
    checkAfter(2, 32'h30,    "beq taken");
    checkAfter(2, 32'h34,    "bne not taken");
    checkAfter(2, 32'h38,    "lui");
    checkAfter(2, 32'h3C,    "addi");
    checkAfter(2, 32'h10040, "jalr target");
    checkAfter(3, 32'h10044, "sw after jalr");
    checkAfter(2, 32'h10048, "addi x7");
    checkAfter(2, 32'h10050, "blt taken");
    checkAfter(2, 32'h10054, "bltu not taken");
    checkAfter(2, 32'h1005C, "bge taken");
    checkAfter(2, 32'h10060, "bgeu not taken");
    checkAfter(2, 32'h10068, "jal link");
    checkAfter(3, 32'h1006C, "sw x8");
    checkAfter(2, 32'h10070, "auipc");
    waitDrain("control flow stores");

    // Fetch stall, then a load whose rd is also its base register stalled on the data side
    startReset();
    i_valid_i = 1'b0;
    i_valid_d = 1'b0;
    dmem[64] = 32'hCAFE_F00D;
    imem[0]  = itype(12'h100, 5'd1, 3'b010, 5'd1, LDO);
    imem[1]  = stype(12'h134, 5'd1, 5'd0, 3'b010);
    expectStore(32'h134, 4'b1111, 32'hCAFE_F00D);
    releaseReset();
    for (int s = 0; s < 3; s++) checkAfter(1, 32'h0, "fetch stall addr_i");
    checkOutput("fetch stall rd_d", {31'b0, o_rd_d}, 32'h0);
    i_valid_i = 1'b1;
    repeat (2) @(posedge i_clk);
    for (int s = 0; s < 3; s++) begin
      #1;
      checkOutput("load stall rd_d", {31'b0, o_rd_d}, 32'h1);
      checkOutput("load stall addr_d", o_addr_d, 32'h100);
      checkOutput("load stall addr_i", o_addr_i, 32'h0);
      @(posedge i_clk);
    end
    #1 i_valid_d = 1'b1;
    checkAfter(1, 32'h4, "load done addr_i");
    checkOutput("load done rd_d", {31'b0, o_rd_d}, 32'h0);
    waitDrain("stalled load");

    // Asynchronous reset in the middle of a stalled store
    startReset();
    i_valid_d = 1'b0;
    imem[0] = itype(12'h003, 5'd0, 3'b000, 5'd1, OPI);
    imem[1] = stype(12'h140, 5'd1, 5'd0, 3'b010);
    releaseReset();
    repeat (4) @(posedge i_clk);
    #1;
    checkOutput("store mem we_d", {28'b0, o_we_d}, 32'hF);
    checkOutput("store mem addr_d", o_addr_d, 32'h140);
    #2 i_rst = 1'b1;
    #1;
    checkOutput("async reset we_d", {28'b0, o_we_d}, 32'h0);
    checkOutput("async reset addr_d", o_addr_d, 32'h0);
    checkOutput("async reset addr_i", o_addr_i, 32'h0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_valid_d = 1'b1;
    expectStore(32'h140, 4'b1111, 32'h3);
    checkAfter(2, 32'h4, "restart addr_i");
    waitDrain("restart store");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
